// File: rtl/grant_transfer_ctrl.sv
// Burst transfer controller: latches the arbiter's granted client and streams its beats out.
// Optional stall timeout is built only when XFER_TIMEOUT_EN is defined.
module grant_transfer_ctrl #(
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grt_0,
    input  logic              grt_1,
    input  logic [LEN_W-1:0]  len_0,
    input  logic [LEN_W-1:0]  len_1,
    input  logic              src_valid_0,
    input  logic              src_valid_1,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_owner,
    output logic              rd_0,
    output logic              rd_1,
    output logic              done_0,
    output logic              done_1,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               owner, owner_next;
    logic [LEN_W-1:0]   cnt, cnt_next;
    logic               src_valid_sel;
    logic               accept;
    logic               timeout;

    assign src_valid_sel = owner ? src_valid_1 : src_valid_0;
    assign accept        = (state == XFER) && src_valid_sel && out_ready;
    assign busy          = (state != IDLE);

`ifdef XFER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall;
    logic               err_q;

    // Stall counter is held at zero outside XFER so every burst starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state != XFER || accept)
                stall <= '0;
            else
                stall <= stall + 1'b1;
        end
    end

    assign timeout = (state == XFER) && !accept && (stall == STALL_W'(TIMEOUT_CYC - 1));
    assign err     = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYC[0];
    assign timeout            = 1'b0;
    assign err                = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        cnt_next   = cnt;
        out_valid  = 1'b0;
        out_data   = '0;
        out_owner  = 1'b0;
        rd_0       = 1'b0;
        rd_1       = 1'b0;
        done_0     = 1'b0;
        done_1     = 1'b0;
        case (state)
            IDLE: begin
                // Client 0 wins if the arbiter ever raises both grants.
                if (grt_0) begin
                    state_next = XFER;
                    owner_next = 1'b0;
                    cnt_next   = len_0;
                end else if (grt_1) begin
                    state_next = XFER;
                    owner_next = 1'b1;
                    cnt_next   = len_1;
                end
            end
            XFER: begin
                out_valid = src_valid_sel;
                out_data  = owner ? data_1 : data_0;
                out_owner = owner;
                rd_0      = accept && !owner;
                rd_1      = accept && owner;
                if (accept) begin
                    if (cnt == '0)
                        state_next = DONE;
                    else
                        cnt_next = cnt - 1'b1;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                out_owner  = owner;
                done_0     = !owner;
                done_1     = owner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_grant_transfer_ctrl.sv
// Scoreboard bench for grant_transfer_ctrl: directed bursts, monitor pops expected beats/dones.
module tb_grant_transfer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       grt_0, grt_1;
    logic [3:0] len_0, len_1;
    logic       src_valid_0, src_valid_1;
    logic [7:0] data_0, data_1;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_owner;
    logic       rd_0, rd_1, done_0, done_1, busy, err;

    int errors = 0;
    int checks = 0;

    logic [8:0] sbq[$];
    logic       doneq[$];
    logic [7:0] pop0 = 8'd0;
    logic [7:0] pop1 = 8'd0;
    logic [7:0] exp0 = 8'd0;
    logic [7:0] exp1 = 8'd0;

    // Client FIFOs: head data advances by one each time the client is popped.
    assign data_0 = 8'h10 + pop0;
    assign data_1 = 8'hA0 + pop1;

    always #5 clk = ~clk;

    grant_transfer_ctrl #(.DATA_W(8), .LEN_W(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .grt_0(grt_0), .grt_1(grt_1),
        .len_0(len_0), .len_1(len_1), .src_valid_0(src_valid_0), .src_valid_1(src_valid_1),
        .data_0(data_0), .data_1(data_1), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_owner(out_owner), .rd_0(rd_0), .rd_1(rd_1),
        .done_0(done_0), .done_1(done_1), .busy(busy), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic who, input int n);
        for (int k = 0; k < n; k++) begin
            if (!who) begin
                sbq.push_back({1'b0, 8'h10 + exp0});
                exp0 = exp0 + 8'd1;
            end else begin
                sbq.push_back({1'b1, 8'hA0 + exp1});
                exp1 = exp1 + 8'd1;
            end
        end
    endtask

    // Monitor: compares every accepted beat and every done pulse against the queues.
    always @(negedge clk) begin
        logic [8:0] eb;
        logic       ed;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("beat_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                eb = sbq.pop_front();
                check("beat_owner", 32'(out_owner), 32'(eb[8]));
                check("beat_data", 32'(out_data), 32'(eb[7:0]));
            end
            check("rd_on_accept", 32'({rd_1, rd_0}), out_owner ? 32'd2 : 32'd1);
        end else begin
            check("rd_no_accept", 32'({rd_1, rd_0}), 32'd0);
        end
        if (done_0 || done_1) begin
            if (doneq.size() == 0) begin
                check("done_unexpected", 32'({done_1, done_0}), 32'd0);
            end else begin
                ed = doneq.pop_front();
                check("done_client", 32'({done_1, done_0}), ed ? 32'd2 : 32'd1);
            end
        end
`ifndef XFER_TIMEOUT_EN
        check("err_tied_low", 32'(err), 32'd0);
`endif
        if (rd_0) pop0 = pop0 + 8'd1;
        if (rd_1) pop1 = pop1 + 8'd1;
    end

    initial begin
        reset = 1'b0; grt_0 = 1'b0; grt_1 = 1'b0; len_0 = 4'd0; len_1 = 4'd0;
        src_valid_0 = 1'b0; src_valid_1 = 1'b0; out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_outputs", 32'({out_owner, rd_0, rd_1, done_0, done_1, busy, err}), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // 1: four beats from client 0, done one cycle after the last beat
        grt_0 = 1'b1; len_0 = 4'd3; src_valid_0 = 1'b1; src_valid_1 = 1'b1; out_ready = 1'b1;
        push_beats(1'b0, 4); doneq.push_back(1'b0);
        tick();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_first_beat", 32'({out_valid, out_owner}), 32'd2);
        grt_0 = 1'b0;
        repeat (4) tick();
        check("t1_done_state", 32'({busy, done_0}), 32'd3);
        tick();
        check("t1_idle", 32'(busy), 32'd0);
        tick();

        // 2: grant switches mid-burst; ownership stays with client 0
        grt_0 = 1'b1; len_0 = 4'd3; len_1 = 4'd1;
        push_beats(1'b0, 4); doneq.push_back(1'b0);
        push_beats(1'b1, 2); doneq.push_back(1'b1);
        tick();
        grt_0 = 1'b0; grt_1 = 1'b1;
        repeat (2) tick();
        check("t2_owner_held", 32'(out_owner), 32'd0);
        repeat (3) tick();
        check("t2_gap_idle", 32'(busy), 32'd0);
        tick();
        check("t2_client1_start", 32'({busy, out_owner}), 32'd3);
        grt_1 = 1'b0;
        repeat (4) tick();

        // 3: both grants in IDLE, client 0 wins; client 1 follows after one idle cycle
        grt_0 = 1'b1; grt_1 = 1'b1; len_0 = 4'd0; len_1 = 4'd0;
        push_beats(1'b0, 1); doneq.push_back(1'b0);
        push_beats(1'b1, 1); doneq.push_back(1'b1);
        tick();
        check("t3_priority", 32'(out_owner), 32'd0);
        grt_0 = 1'b0;
        repeat (2) tick();
        check("t3_gap_idle", 32'(busy), 32'd0);
        tick();
        check("t3_second_owner", 32'(out_owner), 32'd1);
        grt_1 = 1'b0;
        repeat (3) tick();

        // 4: out_ready toggling during a 3-beat client 1 burst
        grt_1 = 1'b1; len_1 = 4'd2; out_ready = 1'b0;
        push_beats(1'b1, 3); doneq.push_back(1'b1);
        tick();
        grt_1 = 1'b0;
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        check("t4_stalled_busy", 32'(busy), 32'd1);
        out_ready = 1'b1; tick();
        check("t4_done_state", 32'({busy, done_1}), 32'd3);
        repeat (2) tick();

        // 5: reset during beat 2 of 4 aborts without done; next grant is a fresh burst
        grt_0 = 1'b1; len_0 = 4'd3;
        push_beats(1'b0, 1);
        tick();
        grt_0 = 1'b0;
        tick();
        #1 reset = 1'b1;
        #1;
        check("t5_async_outputs", 32'({out_valid, rd_0, busy, done_0, out_owner}), 32'd0);
        check("t5_async_data", 32'(out_data), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        grt_0 = 1'b1; len_0 = 4'd1;
        push_beats(1'b0, 2); doneq.push_back(1'b0);
        tick();
        grt_0 = 1'b0;
        repeat (3) tick();
        check("t5_fresh_done_idle", 32'(busy), 32'd0);

        // Longest burst: len=15 gives 16 beats
        grt_0 = 1'b1; len_0 = 4'd15;
        push_beats(1'b0, 16); doneq.push_back(1'b0);
        tick();
        grt_0 = 1'b0;
        repeat (15) tick();
        check("max_still_xfer", 32'({busy, out_valid}), 32'd3);
        tick();
        check("max_done_state", 32'({busy, done_0, out_valid}), 32'd6);
        tick();
        check("max_idle", 32'(busy), 32'd0);

        // 6: downstream never ready
        grt_0 = 1'b1; len_0 = 4'd0; out_ready = 1'b0;
        tick();
        grt_0 = 1'b0;
`ifdef XFER_TIMEOUT_EN
        repeat (15) tick();
        check("t6_before_timeout", 32'({busy, err}), 32'd2);
        tick();
        check("t6_timeout", 32'({busy, err, done_0}), 32'd2);
        tick();
        check("t6_err_pulse", 32'(err), 32'd0);
        out_ready = 1'b1;
`else
        repeat (20) tick();
        check("t6_wait_busy", 32'({busy, out_valid, rd_0}), 32'd6);
        push_beats(1'b0, 1); doneq.push_back(1'b0);
        out_ready = 1'b1;
        repeat (2) tick();
        check("t6_idle_after", 32'(busy), 32'd0);
`endif
        repeat (3) tick();
        check("sb_beats_drained", 32'(sbq.size()), 32'd0);
        check("sb_dones_drained", 32'(doneq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
